// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM with memory wait states, retire pulse and sticky trap
module multicycle_controller #(
   parameter int MEM_WAIT     = 0,
   parameter bit ENABLE_ITYPE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] imm_src,
   output logic       instr_done,
   output logic       illegal_instr
);
   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADR   = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_EXEC_R    = 4'd6;
   localparam logic [3:0] S_EXEC_I    = 4'd7;
   localparam logic [3:0] S_ALU_WB    = 4'd8;
   localparam logic [3:0] S_BEQ       = 4'd9;
   localparam logic [3:0] S_JAL       = 4'd10;
   localparam logic [3:0] S_TRAP      = 4'd11;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [3:0] WAIT_N = 4'(MEM_WAIT);
   logic [3:0] state_q, state_d, wcnt_q, wcnt_d, dec_next, nxt;
   logic       mem_state, last, hold;
   logic       pc_update, branch, ir_s, mw_s, rw_s, done_s, ill_s;
   assign mem_state = state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE;
   assign last      = wcnt_q == WAIT_N;
   // memory states stretch until the wait counter reaches MEM_WAIT
   assign hold      = mem_state && !last;
   always_comb begin
      case (opcode)
         OP_LW, OP_SW: dec_next = S_MEM_ADR;
         OP_R:         dec_next = S_EXEC_R;
         OP_I:         dec_next = ENABLE_ITYPE ? S_EXEC_I : S_TRAP;
         OP_BEQ:       dec_next = S_BEQ;
         OP_JAL:       dec_next = S_JAL;
         default:      dec_next = S_TRAP;
      endcase
   end
   always_comb begin
      nxt = state_q;
      case (state_q)
         S_FETCH:                              nxt = S_DECODE;
         S_DECODE:                             nxt = dec_next;
         S_MEM_ADR:                            nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:                           nxt = S_MEM_WB;
         S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BEQ: nxt = S_FETCH;
         S_EXEC_R, S_EXEC_I, S_JAL:            nxt = S_ALU_WB;
         default:                              nxt = S_TRAP;
      endcase
      state_d = hold ? state_q : nxt;
      wcnt_d  = hold ? wcnt_q + 4'd1 : 4'd0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         wcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end
   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      ir_s       = 1'b0;
      mw_s       = 1'b0;
      rw_s       = 1'b0;
      done_s     = 1'b0;
      ill_s      = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_s       = last;
            pc_update  = last;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEM_ADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEM_READ: adr_src = 1'b1;
         S_MEM_WB: begin
            result_src = 2'b01;
            rw_s       = 1'b1;
            done_s     = 1'b1;
         end
         S_MEM_WRITE: begin
            adr_src = 1'b1;
            mw_s    = last;
            done_s  = last;
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALU_WB: begin
            rw_s   = 1'b1;
            done_s = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
            done_s    = 1'b1;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         default: ill_s = 1'b1;
      endcase
   end
   // strobes are forced low while reset is held so nothing fires from the reset FETCH state
   assign pc_write      = !rst && (pc_update || (branch && zero));
   assign ir_write      = !rst && ir_s;
   assign mem_write     = !rst && mw_s;
   assign reg_write     = !rst && rw_s;
   assign instr_done    = !rst && done_s;
   assign illegal_instr = !rst && ill_s;
   assign imm_src = (opcode == OP_SW)  ? 2'b01 :
                    (opcode == OP_BEQ) ? 2'b10 :
                    (opcode == OP_JAL) ? 2'b11 : 2'b00;
endmodule
